// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the board PLL, the reset button and the
// reset sequencer.
//   pll_locked      PLL LOCKED status, asynchronous to the board clock
//   ext_reset_n     external reset button, active-low, asynchronous
//   pll_rst         PLL RST request, active-high
//   rst_n_out       synchronous active-low reset for the SoC clock domain
//   ready           high while the SoC is released
//   lock_loss_count saturating count of lock losses seen while released
// slave  : the sequencer side (consumes status, drives resets)
// master : the board/environment side
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       ext_reset_n;
  logic       pll_rst;
  logic       rst_n_out;
  logic       ready;
  logic [7:0] lock_loss_count;

  modport slave (
    input  pll_locked, ext_reset_n,
    output pll_rst, rst_n_out, ready, lock_loss_count
  );

  modport master (
    output pll_locked, ext_reset_n,
    input  pll_rst, rst_n_out, ready, lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and SoC reset sequencer. Runs on the free-running board clock
// so it keeps working while the PLL is unlocked. Pulses the PLL reset,
// waits (with timeout) for lock, qualifies lock as stable, then holds the SoC
// in reset for a few more cycles before releasing it. Lock loss restarts the
// PLL bring-up; the external button only re-enters the hold phase.
//
// Ports:
//   clk_in  free-running board clock
//   reset   asynchronous active-low block reset
//   bus     pll_reset_sequencer_if.slave (see interface file)
//
// Optional feature macro: PLL_LOCK_LOSS_COUNTER_EN
//   defined   : lock_loss_count counts lock losses in RUN, saturating at 255
//   undefined : no counter register, lock_loss_count tied to 0
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES         = 16,
  parameter int CNT_W               = 17
) (
  input logic                  clk_in,
  input logic                  reset,
  pll_reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_HOLD,
    S_RUN
  } state_e;

  // Terminal counts: a phase of N cycles ends on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] T_RST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_HOLD    = CNT_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, ext_sync_q;
  logic               lock_s, ext_s;
  logic               pll_rst_q, rst_n_out_q, ready_q;

  // Input synchronizers. The ext chain resets to 1 so a reset release never
  // looks like a button press.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lock_sync_q <= '0;
      ext_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], bus.ext_reset_n};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign ext_s  = ext_sync_q[SYNC_STAGES-1];

  // Next state. Within each state lock loss is checked before the button,
  // and both before counter expiry.
  always_comb begin
    logic cnt_clr;
    state_d = state_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == T_RST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s)                  state_d = S_STABLE;
        else if (cnt_q == T_TIMEOUT) state_d = S_PLL_RST;
      end
      S_STABLE: begin
        // A drop here is treated as a glitch: just go back to waiting.
        if (!lock_s)                state_d = S_WAIT_LOCK;
        else if (cnt_q == T_STABLE) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s)              state_d = S_PLL_RST;
        else if (!ext_s)          cnt_clr = 1'b1;
        else if (cnt_q == T_HOLD) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s)     state_d = S_PLL_RST;
        else if (!ext_s) state_d = S_HOLD;
      end
      default: state_d = S_PLL_RST;
    endcase

    // One shared counter, restarted on every state change. RUN has no
    // timed exit, so the counter simply parks there.
    if ((state_d != state_q) || cnt_clr) cnt_d = '0;
    else if (state_q == S_RUN)           cnt_d = cnt_q;
    else                                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered from the next state, so they change on the same
  // edge the state does and never see a combinational path from the pins.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pll_rst_q   <= 1'b1;
      rst_n_out_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == S_PLL_RST);
      rst_n_out_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.rst_n_out = rst_n_out_q;
  assign bus.ready     = ready_q;

`ifdef PLL_LOCK_LOSS_COUNTER_EN
  logic       loss_evt;
  logic [7:0] loss_cnt_q;

  // Only losses from RUN count; drops during bring-up are expected.
  assign loss_evt = (state_q == S_RUN) && !lock_s;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                             loss_cnt_q <= 8'd0;
    else if (loss_evt && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
  end

  assign bus.lock_loss_count = loss_cnt_q;
`else
  assign bus.lock_loss_count = 8'd0;
`endif

  // Sanity properties on the registered outputs.
  a_ready_rst: assert property (@(posedge clk_in) disable iff (!reset)
    ready_q == rst_n_out_q);
  a_rst_excl: assert property (@(posedge clk_in) disable iff (!reset)
    !(pll_rst_q && rst_n_out_q));

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized/directed bench for pll_reset_sequencer. A reference model,
// kept in terms of phases and elapsed time, pushes the expected outputs for
// every clock into a queue; a monitor pops and compares on the falling edge.
module tb_pll_reset_sequencer;
  localparam int SYNC = 2;
  localparam int RSTC = 3;
  localparam int TO   = 32;
  localparam int STB  = 8;
  localparam int HLD  = 4;
`ifdef PLL_LOCK_LOSS_COUNTER_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lock_in = 1'b0;
  logic ext_in = 1'b1;

  pll_reset_sequencer_if bus();
  assign bus.pll_locked  = lock_in;
  assign bus.ext_reset_n = ext_in;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(RSTC), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(STB), .HOLD_CYCLES(HLD), .CNT_W(17)
  ) dut (
    .clk_in(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pll_rst;
    logic       rst_n_out;
    logic       ready;
    logic [7:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   vec  = 0;
  int   errs = 0;

  // ---------------- reference model ----------------
  localparam int M_RST = 0, M_WAIT = 1, M_STB = 2, M_HOLD = 3, M_RUN = 4;
  int m_phase = M_RST;
  int m_age   = 0;
  int m_loss  = 0;
  bit lq[$];
  bit eq[$];

  function automatic int dwell(input int ph);
    case (ph)
      M_RST:   return RSTC;
      M_WAIT:  return TO;
      M_STB:   return STB;
      default: return HLD;
    endcase
  endfunction

  function automatic int on_expiry(input int ph);
    case (ph)
      M_RST:   return M_WAIT;
      M_WAIT:  return M_RST;
      M_STB:   return M_HOLD;
      default: return M_RUN;
    endcase
  endfunction

  function automatic void m_reset();
    m_phase = M_RST;
    m_age   = 0;
    m_loss  = 0;
    lq.delete();
    eq.delete();
    for (int i = 0; i < SYNC; i++) begin
      lq.push_back(1'b0);
      eq.push_back(1'b1);
    end
  endfunction

  // l/e: pin values as seen after the synchronizer delay
  function automatic void m_step(input bit l, input bit e);
    int nxt;
    nxt = m_phase;
    if (m_phase == M_RUN) begin
      if (!l) begin
        nxt = M_RST;
        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      end else if (!e) nxt = M_HOLD;
    end else if (m_phase == M_STB && !l)  nxt = M_WAIT;
    else if (m_phase == M_HOLD && !l)     nxt = M_RST;
    else if (m_phase == M_WAIT && l)      nxt = M_STB;

    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age   = 0;
    end else if (m_phase == M_HOLD && !e) begin
      m_age = 0;
    end else if (m_phase != M_RUN) begin
      m_age++;
      if (m_age == dwell(m_phase)) begin
        m_phase = on_expiry(m_phase);
        m_age   = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit   l, e;
    exp_t x;
    if (!reset) m_reset();
    else begin
      l = lq.pop_front();
      e = eq.pop_front();
      lq.push_back(lock_in);
      eq.push_back(ext_in);
      m_step(l, e);
    end
    x.pll_rst   = (m_phase == M_RST);
    x.rst_n_out = (m_phase == M_RUN);
    x.ready     = (m_phase == M_RUN);
    x.cnt       = LOSS_EN ? 8'(m_loss) : 8'd0;
    expq.push_back(x);
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      exp_t x, g;
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        g = {bus.pll_rst, bus.rst_n_out, bus.ready, bus.lock_loss_count};
        vec++;
        if (g !== x) begin
          errs++;
          $display("FAIL outputs t=%0t got pll_rst=%b rst_n_out=%b ready=%b cnt=%0d, expected pll_rst=%b rst_n_out=%b ready=%b cnt=%0d",
                   $time, g.pll_rst, g.rst_n_out, g.ready, g.cnt,
                   x.pll_rst, x.rst_n_out, x.ready, x.cnt);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    vec++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_phase(input int ph, input int bound, input string nm);
    int k = 0;
    while (m_phase != ph && k < bound) begin
      tick(1);
      k++;
    end
    if (m_phase != ph) begin
      vec++;
      errs++;
      $display("FAIL timeout %s: phase %0d, wanted %0d", nm, m_phase, ph);
    end
  endtask

  // Count clocks until the selected output takes value val (-1 on timeout).
  // sel 0 = pll_rst, 1 = rst_n_out
  task automatic measure(input int sel, input logic val, input int bound, output int n);
    logic s;
    n = 0;
    do begin
      tick(1);
      n++;
      s = (sel == 0) ? bus.pll_rst : bus.rst_n_out;
    end while (s !== val && n < bound);
    if (s !== val) n = -1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    int k;
    tick(3);
    chk("reset pll_rst", bus.pll_rst, 1);
    chk("reset rst_n_out", bus.rst_n_out, 0);
    chk("reset count", bus.lock_loss_count, 0);
    reset = 1'b1;

    // Clean bring-up: pll_rst pulse length, then lock 10 cycles later.
    measure(0, 1'b0, 20, n);
    chk("pll_rst pulse", n, RSTC);
    tick(9);
    lock_in = 1'b1;
    measure(1, 1'b1, 40, n);
    // first sampling edge plus 2+8+4 edges
    chk("lock to release", n, 1 + SYNC + STB + HLD);
    chk("ready with rst_n_out", bus.ready, 1);

    // Lock loss in RUN, then keep lock low to exercise the timeout loop.
    lock_in = 1'b0;
    measure(1, 1'b0, 10, n);
    chk("loss to rst_n_out fall", n, SYNC + 1);
    tick(120);

    // Glitch in STABLE after 5 stable cycles.
    lock_in = 1'b1;
    wait_phase(M_STB, 60, "enter STABLE");
    k = 0;
    while (m_age != 5 && k < 20) begin
      tick(1);
      k++;
    end
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    wait_phase(M_RUN, 60, "after glitch");
    chk("count after glitch", bus.lock_loss_count, LOSS_EN ? 1 : 0);

    // External reset for 20 cycles in RUN.
    ext_in = 1'b0;
    tick(20);
    chk("ext held low", bus.rst_n_out, 0);
    ext_in = 1'b1;
    measure(1, 1'b1, 20, n);
    chk("ext release", n, SYNC + HLD);

    // Lock loss and button press on the same cycle.
    lock_in = 1'b0;
    ext_in  = 1'b0;
    tick(4);
    chk("simul pll_rst", bus.pll_rst, 1);
    chk("simul count", bus.lock_loss_count, LOSS_EN ? 2 : 0);
    lock_in = 1'b1;
    ext_in  = 1'b1;
    wait_phase(M_RUN, 80, "after simul");

    // Block reset in the middle of HOLD.
    ext_in = 1'b0;
    wait_phase(M_HOLD, 10, "enter HOLD");
    tick(1);
    reset = 1'b0;
    #1;
    chk("async reset outputs", {bus.pll_rst, bus.rst_n_out, bus.ready}, 3'b100);
    ext_in = 1'b1;
    tick(3);
    reset = 1'b1;
    wait_phase(M_RUN, 80, "after reset");

    // 300 lock losses: count must saturate.
    for (int r = 0; r < 300; r++) begin
      wait_phase(M_RUN, 80, "saturation round");
      lock_in = 1'b0;
      tick(int'($urandom_range(1, 4)));
      lock_in = 1'b1;
    end
    wait_phase(M_RUN, 80, "saturation end");
    chk("saturated count", bus.lock_loss_count, LOSS_EN ? 255 : 0);

    // Random sticky toggling of lock and button.
    for (int c = 0; c < 2000; c++) begin
      if (lock_in) lock_in = ($urandom_range(0, 99) >= 2);
      else         lock_in = ($urandom_range(0, 99) < 20);
      if (ext_in)  ext_in  = ($urandom_range(0, 99) >= 2);
      else         ext_in  = ($urandom_range(0, 99) < 15);
      tick(1);
    end

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
